// File: rtl/joypad_pkg.sv
// Shared constants and types for the two-port serial joypad interface.
package joypad_pkg;

    localparam logic [15:0] JOY0_ADDR = 16'h4016;
    localparam logic [15:0] JOY1_ADDR = 16'h4017;

    localparam int unsigned PULSE_LEN_DEFAULT = 4;

    typedef enum logic {
        IDLE,
        PULSE
    } port_state_e;

endpackage

// File: rtl/joypad_chan.sv
// One joypad channel: pad data synchronizer plus the shift-clock pulse generator.
module joypad_chan
    import joypad_pkg::*;
#(
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_data_i,
    input  logic latch_i,
    input  logic start_i,
    output logic bit_o,
    output logic js_clk_o
);

    localparam logic [3:0] CNT_LOAD = 4'(PULSE_LEN - 1);

    logic [1:0]  sync_q;
    port_state_e state_q;
    logic [3:0]  cnt_q;
    logic        js_clk_q;

    // Pad data is asynchronous and active-low; idle pads read back as 0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pad_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            js_clk_q <= 1'b1;
        end else if (state_q == IDLE) begin
            if (start_i && !latch_i) begin
                state_q  <= PULSE;
                cnt_q    <= CNT_LOAD;
                js_clk_q <= 1'b0;
            end
        end else begin
            // Latch and further reads are ignored here so a pulse always runs to length.
            if (cnt_q == 4'd0) begin
                state_q  <= IDLE;
                js_clk_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    assign bit_o    = ~sync_q[1];
    assign js_clk_o = js_clk_q;

endmodule

// File: rtl/joypad_port.sv
// CPU-facing joypad port at 4016/4017; define JOYPAD_OPEN_BUS_EN for open-bus high bits.
module joypad_port
    import joypad_pkg::*;
#(
    parameter int unsigned PULSE_LEN = PULSE_LEN_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        mem_en,
    input  logic        mem_rw,
    output logic [7:0]  data_out,
    output logic        rd_valid,
    output logic        js_latch,
    output logic        js_clk0,
    output logic        js_clk1,
    input  logic        js_data0,
    input  logic        js_data1
);

`ifdef JOYPAD_OPEN_BUS_EN
    localparam logic [2:0] HI_BITS = 3'b010;
`else
    localparam logic [2:0] HI_BITS = 3'b000;
`endif

    logic       rd0, rd1, wr0;
    logic       bit0, bit1;
    logic       latch_q, latch_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_unused;

    assign rd0 = mem_en && mem_rw && (addr == JOY0_ADDR);
    assign rd1 = mem_en && mem_rw && (addr == JOY1_ADDR);
    assign wr0 = mem_en && !mem_rw && (addr == JOY0_ADDR);

    assign data_unused = ^data_in[7:1];

    joypad_chan #(.PULSE_LEN(PULSE_LEN)) u_chan0 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pad_data_i (js_data0),
        .latch_i    (latch_q),
        .start_i    (rd0),
        .bit_o      (bit0),
        .js_clk_o   (js_clk0)
    );

    joypad_chan #(.PULSE_LEN(PULSE_LEN)) u_chan1 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pad_data_i (js_data1),
        .latch_i    (latch_q),
        .start_i    (rd1),
        .bit_o      (bit1),
        .js_clk_o   (js_clk1)
    );

    always_comb begin
        latch_d    = latch_q;
        rd_valid_d = rd0 || rd1;
        data_out_d = 8'h00;
        if (wr0) begin
            latch_d = data_in[0];
        end
        if (rd0) begin
            data_out_d = {HI_BITS, 4'b0000, bit0};
        end else if (rd1) begin
            data_out_d = {HI_BITS, 4'b0000, bit1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            data_out_q <= 8'h00;
        end else begin
            latch_q    <= latch_d;
            rd_valid_q <= rd_valid_d;
            data_out_q <= data_out_d;
        end
    end

    assign js_latch = latch_q;
    assign rd_valid = rd_valid_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_joypad_port.sv
// Scoreboard bench for joypad_port; expected read data is queued when each read is driven.
module tb_joypad_port;
    import joypad_pkg::*;

`ifdef JOYPAD_OPEN_BUS_EN
    localparam logic [2:0] HI = 3'b010;
`else
    localparam logic [2:0] HI = 3'b000;
`endif
    localparam int PULSE_LEN_TB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  data_in = 8'h00;
    logic        mem_en = 1'b0;
    logic        mem_rw = 1'b0;
    logic [7:0]  data_out;
    logic        rd_valid;
    logic        js_latch;
    logic        js_clk0;
    logic        js_clk1;
    logic        js_data0 = 1'b1;
    logic        js_data1 = 1'b1;

    int          assertCount = 0;
    int          failCount = 0;
    logic [7:0]  expQ[$];
    logic [7:0]  expData;
    int          runs0[$];
    int          runs1[$];
    int          run0 = 0;
    int          run1 = 0;
    bit          monitorOn = 1'b0;

    joypad_port #(.PULSE_LEN(PULSE_LEN_TB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .mem_en   (mem_en),
        .mem_rw   (mem_rw),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .js_latch (js_latch),
        .js_clk0  (js_clk0),
        .js_clk1  (js_clk1),
        .js_data0 (js_data0),
        .js_data1 (js_data1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One bus cycle, sampled on the next posedge; valid pad reads queue their expected data.
    task automatic applyStimulus(input logic en, input logic rw, input logic [15:0] a, input logic [7:0] d);
        mem_en  = en;
        mem_rw  = rw;
        addr    = a;
        data_in = d;
        if (en && rw && a == JOY0_ADDR) expQ.push_back({HI, 4'b0000, ~js_data0});
        if (en && rw && a == JOY1_ADDR) expQ.push_back({HI, 4'b0000, ~js_data1});
        @(posedge clk);
        #1;
        mem_en  = 1'b0;
        mem_rw  = 1'b0;
        addr    = 16'h0000;
        data_in = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectRun(input int port, input int len);
        int got;
        if (port == 0) got = (runs0.size() > 0) ? runs0.pop_front() : -1;
        else           got = (runs1.size() > 0) ? runs1.pop_front() : -1;
        checkOutput($sformatf("clk%0d_low_len", port), got, len);
    endtask

    // Scoreboard pop and shift-clock low-run measurement.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (rd_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_rd_valid", 32'(rd_valid), 32'd0);
                end else begin
                    expData = expQ.pop_front();
                    checkOutput("rd_data", 32'(data_out), 32'(expData));
                end
            end else begin
                checkOutput("idle_data_out", 32'(data_out), 32'd0);
            end
            if (!js_clk0) run0++;
            else if (run0 != 0) begin runs0.push_back(run0); run0 = 0; end
            if (!js_clk1) run1++;
            else if (run1 != 0) begin runs1.push_back(run1); run1 = 0; end
        end
    end

    initial begin
        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_js_clk0", 32'(js_clk0), 32'd1);
        checkOutput("rst_js_clk1", 32'(js_clk1), 32'd1);
        checkOutput("rst_js_latch", 32'(js_latch), 32'd0);
        checkOutput("rst_data_out", 32'(data_out), 32'd0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;
        monitorOn = 1'b1;

        // Strobe then read with button pressed.
        js_data0 = 1'b0;
        idle(3);
        applyStimulus(1'b1, 1'b0, JOY0_ADDR, 8'h01);
        checkOutput("latch_set", 32'(js_latch), 32'd1);
        applyStimulus(1'b1, 1'b0, JOY0_ADDR, 8'h00);
        checkOutput("latch_clr", 32'(js_latch), 32'd0);
        applyStimulus(1'b1, 1'b1, JOY0_ADDR, 8'h00);
        checkOutput("clk0_low_after_read", 32'(js_clk0), 32'd0);
        idle(6);
        expectRun(0, PULSE_LEN_TB);
        checkOutput("clk0_idle_high", 32'(js_clk0), 32'd1);

        // Button released.
        js_data0 = 1'b1;
        idle(3);
        applyStimulus(1'b1, 1'b1, JOY0_ADDR, 8'h00);
        idle(6);
        expectRun(0, PULSE_LEN_TB);

        // Second read during a pulse returns data but does not extend it.
        js_data0 = 1'b0;
        idle(3);
        applyStimulus(1'b1, 1'b1, JOY0_ADDR, 8'h00);
        idle(1);
        applyStimulus(1'b1, 1'b1, JOY0_ADDR, 8'h00);
        idle(6);
        expectRun(0, PULSE_LEN_TB);
        checkOutput("overlap_single_pulse", 32'(runs0.size()), 32'd0);

        // Latch set mid-pulse does not truncate it.
        applyStimulus(1'b1, 1'b1, JOY0_ADDR, 8'h00);
        applyStimulus(1'b1, 1'b0, JOY0_ADDR, 8'h01);
        idle(6);
        expectRun(0, PULSE_LEN_TB);
        checkOutput("latch_after_midpulse", 32'(js_latch), 32'd1);

        // Latch held: live data, no pulses.
        js_data1 = 1'b0;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, JOY1_ADDR, 8'h00);
            idle(1);
        end
        js_data1 = 1'b1;
        idle(3);
        applyStimulus(1'b1, 1'b1, JOY1_ADDR, 8'h00);
        applyStimulus(1'b1, 1'b1, JOY0_ADDR, 8'h00);
        idle(6);
        checkOutput("latched_clk1_runs", 32'(runs1.size()), 32'd0);
        checkOutput("latched_clk0_runs", 32'(runs0.size()), 32'd0);
        checkOutput("latched_clk1_high", 32'(js_clk1), 32'd1);
        applyStimulus(1'b1, 1'b0, JOY0_ADDR, 8'h00);

        // Back-to-back reads pulse independent clocks.
        js_data1 = 1'b0;
        idle(3);
        applyStimulus(1'b1, 1'b1, JOY0_ADDR, 8'h00);
        applyStimulus(1'b1, 1'b1, JOY1_ADDR, 8'h00);
        idle(6);
        expectRun(0, PULSE_LEN_TB);
        expectRun(1, PULSE_LEN_TB);

        // Reset on the second low cycle; a read sampled at the reset edge is dropped.
        applyStimulus(1'b1, 1'b1, JOY1_ADDR, 8'h00);
        idle(1);
        rst_n  = 1'b0;
        mem_en = 1'b1;
        mem_rw = 1'b1;
        addr   = JOY0_ADDR;
        @(posedge clk);
        #1;
        checkOutput("midpulse_rst_clk1", 32'(js_clk1), 32'd1);
        checkOutput("midpulse_rst_rd_valid", 32'(rd_valid), 32'd0);
        mem_en = 1'b0;
        mem_rw = 1'b0;
        addr   = 16'h0000;
        rst_n  = 1'b1;
        idle(4);
        expectRun(1, 2);

        // Address decode and enable qualification.
        applyStimulus(1'b1, 1'b0, JOY1_ADDR, 8'hFF);
        checkOutput("wr4017_latch", 32'(js_latch), 32'd0);
        applyStimulus(1'b1, 1'b1, 16'h4018, 8'h00);
        checkOutput("rd4018_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("rd4018_data_out", 32'(data_out), 32'd0);
        applyStimulus(1'b0, 1'b1, JOY0_ADDR, 8'h00);
        checkOutput("noen_rd_valid", 32'(rd_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, JOY0_ADDR, 8'h01);
        checkOutput("noen_latch", 32'(js_latch), 32'd0);
        idle(6);
        checkOutput("decode_clk0_runs", 32'(runs0.size()), 32'd0);
        checkOutput("decode_clk1_runs", 32'(runs1.size()), 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/joypad_port.md
JOYPAD_PORT -- requirements
Module: joypad_port

Interface
REQ-001 The port list SHALL be, in order:
- clk  in  1  sole clock; all state changes on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- addr  in  16  CPU address bus.
- data_in  in  8  CPU write data.
- mem_en  in  1  one-cycle access strobe.
- mem_rw  in  1  1 = read, 0 = write.
- data_out  out  8  read data, registered.
- rd_valid  out  1  one-cycle pulse qualifying data_out.
- js_latch  out  1  pad strobe/latch, shared by both pads.
- js_clk0  out  1  pad 0 shift clock, idle high.
- js_clk1  out  1  pad 1 shift clock, idle high.
- js_data0  in  1  pad 0 serial data, active-low, asynchronous.
- js_data1  in  1  pad 1 serial data, active-low, asynchronous.
REQ-002 Parameter PULSE_LEN SHALL default to 4 and set the js_clkN low time in cycles; the legal range is 1-15.

Function
REQ-003 The block SHALL respond to an access only when mem_en=1; it SHALL ignore all other cycles.
REQ-004 A write (mem_rw=0) to 16'h4016 SHALL load latch_q with data_in[0]; js_latch SHALL equal latch_q from the next cycle.
REQ-005 Writes to any other address, including 16'h4017, SHALL have no effect.
REQ-006 Each js_dataN SHALL pass through a 2-flop synchronizer; the read bit is bitN = ~sync_dataN.
REQ-007 A read (mem_rw=1) of 16'h4016 (port 0) or 16'h4017 (port 1) SHALL produce rd_valid=1 in the next cycle.
REQ-008 On that cycle data_out SHALL be {HI, 4'b0000, bitN}; HI is defined in REQ-017/018.
REQ-009 In all other cycles rd_valid SHALL be 0 and data_out SHALL be 8'h00.
REQ-010 Each port SHALL have a state machine IDLE -> PULSE -> IDLE:
- A read of that port in IDLE with latch_q=0 SHALL enter PULSE on the following cycle.
- In PULSE, js_clkN SHALL be 0 for exactly PULSE_LEN cycles, counted by a 4-bit down-counter.
- The machine SHALL then return to IDLE with js_clkN=1.
REQ-011 A read of a port whose machine is in PULSE SHALL return bitN with rd_valid but SHALL NOT start or extend a pulse.
REQ-012 While latch_q=1, reads SHALL return live bitN and SHALL generate no pulse.
REQ-013 A write setting latch_q=1 during PULSE SHALL NOT truncate the pulse in progress.
REQ-014 The two port machines SHALL be independent; back-to-back reads of 4016 and then 4017 SHALL each pulse their own clock.

Reset
REQ-015 While rst_n=0 at a clock edge, the block SHALL set:
- latch_q=0, js_latch=0;
- js_clk0=js_clk1=1;
- both machines to IDLE with counters at 0;
- data_out=8'h00, rd_valid=0;
- synchronizer flops to 1.
REQ-016 A reset asserted mid-pulse SHALL return js_clkN high on the cycle after the reset edge, and any pending rd_valid SHALL be dropped.

Configuration
REQ-017 With JOYPAD_OPEN_BUS_EN defined, HI SHALL be 3'b010, so reads return 8'h40 or 8'h41 (open-bus emulation).
REQ-018 Without JOYPAD_OPEN_BUS_EN, HI SHALL be 3'b000, so reads return 8'h00 or 8'h01.

Structure
REQ-019 A shared package SHALL hold:
- constants JOY0_ADDR=16'h4016 and JOY1_ADDR=16'h4017;
- the PULSE_LEN default;
- the port-state enum typedef {IDLE, PULSE}.
REQ-020 Per-port logic (synchronizer, state machine, counter, clock output) SHALL be one sub-module, joypad_chan, instantiated twice.

Verification
REQ-021 Reset: hold rst_n=0 for 2 cycles -> js_clk0=js_clk1=1, js_latch=0, data_out=00, rd_valid=0.
REQ-022 Strobe and read: write 4016 with 01 then 00, hold js_data0=0, read 4016 -> rd_valid next cycle, data_out=41 (macro on) or 01 (off), js_clk0 low for 4 cycles then high.
REQ-023 Pulse overlap: read 4016 twice, 2 cycles apart -> two rd_valid pulses, a single 4-cycle js_clk0 low.
REQ-024 Latch held: js_latch=1, read 4017 three times -> three rd_valid pulses, js_clk1 constant 1.
REQ-025 Reset mid-pulse: read 4017, assert rst_n=0 on the 2nd low cycle -> js_clk1=1 on the next cycle, no rd_valid afterwards.
REQ-026 Decode: write FF to 4017, then read 4018 -> js_latch unchanged, rd_valid=0, data_out=00.
